// File: rtl/tamagotchi_cmd_scheduler.sv
// Button front end and command scheduler for the pet core: debounces five buttons,
// keeps one pending flag per command and issues them round-robin over valid/ready.
module tamagotchi_cmd_scheduler #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned LONG_S     = 5
) (
    input  logic       clk,
    input  logic       btn_reset_n,
    input  logic       btn_salud,
    input  logic       btn_energia,
    input  logic       btn_hambre,
    input  logic       btn_diversion,
    input  logic       btn_test,
    input  logic       ledsign,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_sel,
    output logic       cmd_test,
    output logic       test_mode,
    output logic       tick_1s
);

    localparam int unsigned TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_S + 1);

    logic [4:0]    btn_raw, sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q [5];
    logic [DW-1:0] deb_cnt_d [5];
    logic [3:0]    deb_prev_q, press, pend_q, pend_d, acc_mask;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          test_mode_q, test_mode_d;
    logic          cmd_valid_q, cmd_valid_d, cmd_test_q, cmd_test_d;
    logic [1:0]    cmd_sel_q, cmd_sel_d, ptr_q, ptr_d;
    logic [1:0]    search_ptr, winner, cand;
    logic          accept, found;

    // Index 4 is the test-mode button; 0..3 match the command encoding.
    assign btn_raw = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Energy presses only count while the energy qualifier is high.
    assign press = deb_q[3:0] & ~deb_prev_q & {2'b11, ledsign, 1'b1};

    assign accept     = cmd_valid_q & cmd_ready;
    assign acc_mask   = accept ? (4'b0001 << cmd_sel_q) : 4'b0000;
    assign pend_d     = (pend_q & ~acc_mask) | press;
    assign search_ptr = accept ? cmd_sel_q + 2'd1 : ptr_q;
    assign ptr_d      = accept ? search_ptr : ptr_q;

    always_comb begin
        found  = 1'b0;
        winner = search_ptr;
        cand   = search_ptr;
        for (int i = 0; i < 4; i++) begin
            cand = search_ptr + 2'(i);
            if (!found && pend_d[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_sel_d   = cmd_sel_q;
        cmd_test_d  = cmd_test_q;
        if (!cmd_valid_q || accept) begin
            cmd_valid_d = found;
            if (found) begin
                cmd_sel_d  = winner;
                cmd_test_d = test_mode_q;
            end
        end
    end

    assign tick_1s = (tcnt_q == TW'(CLK_FREQ - 1));
    assign tcnt_d  = tick_1s ? '0 : tcnt_q + TW'(1);

    // The toggle fires only on the step into LONG_S; saturation blocks repeats.
    always_comb begin
        hold_d      = hold_q;
        test_mode_d = test_mode_q;
        if (!deb_q[4]) begin
            hold_d = '0;
        end else if (tick_1s && hold_q != HW'(LONG_S)) begin
            hold_d = hold_q + HW'(1);
            if (hold_q == HW'(LONG_S - 1)) begin
                test_mode_d = ~test_mode_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!btn_reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
            pend_q      <= '0;
            ptr_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_sel_q   <= '0;
            cmd_test_q  <= 1'b0;
            tcnt_q      <= '0;
            hold_q      <= '0;
            test_mode_q <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q[3:0];
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_sel_q   <= cmd_sel_d;
            cmd_test_q  <= cmd_test_d;
            tcnt_q      <= tcnt_d;
            hold_q      <= hold_d;
            test_mode_q <= test_mode_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_sel   = cmd_sel_q;
    assign cmd_test  = cmd_test_q;
    assign test_mode = test_mode_q;

endmodule

// File: tb/tb_tamagotchi_cmd_scheduler.sv
// Bench for tamagotchi_cmd_scheduler: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the scheduler rules.
module tb_tamagotchi_cmd_scheduler;

    localparam int CLK  = 100;
    localparam int DEB  = 4;
    localparam int LONG = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic       ledsign, ready;
    logic       cmd_valid, cmd_test, test_mode, tick_1s;
    logic [1:0] cmd_sel;

    int n_checks = 0;
    int n_errors = 0;

    tamagotchi_cmd_scheduler #(
        .CLK_FREQ  (CLK),
        .DEB_CYCLES(DEB),
        .LONG_S    (LONG)
    ) dut (
        .clk          (clk),
        .btn_reset_n  (rst_n),
        .btn_salud    (btn[0]),
        .btn_energia  (btn[1]),
        .btn_hambre   (btn[2]),
        .btn_diversion(btn[3]),
        .btn_test     (btn[4]),
        .ledsign      (ledsign),
        .cmd_ready    (ready),
        .cmd_valid    (cmd_valid),
        .cmd_sel      (cmd_sel),
        .cmd_test     (cmd_test),
        .test_mode    (test_mode),
        .tick_1s      (tick_1s)
    );

    always #5 clk = ~clk;

    // Model state: levels seen through the synchronizer, accepted debounced levels,
    // length of the current disagreeing run, pending set, current command.
    bit [4:0] m_s1, m_s2, m_deb, m_prev;
    int       m_run [5];
    bit [3:0] m_pend;
    bit       m_v, m_t, m_mode, m_rstd;
    int       m_sel, m_ptr, m_hold, m_tcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit [3:0] pe;
        bit       tk, acc;
        int       sp, idx;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0; m_pend = '0;
            m_v = 0; m_t = 0; m_mode = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_tcnt = 0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_rstd = 1;
            return;
        end
        m_rstd = 0;
        for (int i = 0; i < 4; i++) pe[i] = m_deb[i] && !m_prev[i];
        pe[1] = pe[1] && ledsign;
        tk  = (m_tcnt == CLK - 1);
        acc = m_v && ready;
        if (acc) m_pend[m_sel] = 0;
        m_pend = m_pend | pe;
        if (!m_v || acc) begin
            sp = acc ? (m_sel + 1) % 4 : m_ptr;
            if (acc) m_ptr = sp;
            m_v = 0;
            for (int j = 0; j < 4; j++) begin
                idx = (sp + j) % 4;
                if (!m_v && m_pend[idx]) begin
                    m_v = 1; m_sel = idx; m_t = m_mode;
                end
            end
        end
        if (!m_deb[4]) m_hold = 0;
        else if (tk && m_hold < LONG) begin
            m_hold++;
            if (m_hold == LONG) m_mode = !m_mode;
        end
        m_tcnt = (m_tcnt + 1) % CLK;
        m_prev = m_deb;
        for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("cmd_valid", 32'(cmd_valid), 32'(m_v));
        if (m_v || m_rstd) begin
            check_eq("cmd_sel", 32'(cmd_sel), 32'(m_sel));
            check_eq("cmd_test", 32'(cmd_test), 32'(m_t));
        end
        check_eq("test_mode", 32'(test_mode), 32'(m_mode));
        check_eq("tick_1s", 32'(tick_1s), 32'(m_tcnt == CLK - 1));
    endtask

    task automatic do_reset(input int n);
        btn   = '0;
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, vcnt, sel_at, bad, seq, nacc, ticks, rise, chg, tflag;
        int rem [5];
        int rem_l;
        logic prev_mode;
        ledsign = 1'b0;
        ready   = 1'b0;
        do_reset(3);
        check_eq("rst_valid", 32'(cmd_valid), 0);
        check_eq("rst_sel", 32'(cmd_sel), 0);
        check_eq("rst_mode", 32'(test_mode), 0);

        // Single press with consumer always ready.
        ready = 1'b1; lat = 0; vcnt = 0; sel_at = -1;
        for (int k = 1; k <= 20; k++) begin
            btn[2] = (k <= 10);
            step();
            if (cmd_valid) begin
                vcnt++;
                if (lat == 0) begin lat = k; sel_at = 32'(cmd_sel); end
            end
        end
        check_eq("hambre_latency", lat, 7);
        check_eq("hambre_vcycles", vcnt, 1);
        check_eq("hambre_sel", sel_at, 2);

        // Short glitch and a gated energy press must not issue.
        vcnt = 0;
        for (int k = 1; k <= 15; k++) begin btn[0] = (k <= 3); step(); vcnt += 32'(cmd_valid); end
        check_eq("glitch_none", vcnt, 0);
        ledsign = 1'b0; vcnt = 0;
        for (int k = 1; k <= 20; k++) begin btn[1] = (k <= 10); step(); vcnt += 32'(cmd_valid); end
        check_eq("energia_gated", vcnt, 0);
        ledsign = 1'b1; vcnt = 0; sel_at = -1;
        for (int k = 1; k <= 20; k++) begin
            btn[1] = (k <= 10);
            step();
            if (cmd_valid) begin vcnt++; sel_at = 32'(cmd_sel); end
        end
        check_eq("energia_ok_cnt", vcnt, 1);
        check_eq("energia_ok_sel", sel_at, 1);

        // All four at once, long stall, then drain in round-robin order.
        do_reset(2);
        ready = 1'b0; bad = 0; vcnt = 0;
        for (int k = 1; k <= 30; k++) begin
            btn[3:0] = (k <= 10) ? 4'hf : 4'h0;
            step();
            if (cmd_valid) begin vcnt++; if (cmd_sel != 2'd0) bad++; end
        end
        check_eq("stall_cycles", vcnt, 24);
        check_eq("stall_sel_held", bad, 0);
        ready = 1'b1; seq = 0; nacc = 0;
        for (int k = 1; k <= 10; k++) begin
            if (cmd_valid) begin nacc++; seq = seq * 4 + 32'(cmd_sel); end
            step();
        end
        check_eq("rr_count", nacc, 4);
        check_eq("rr_order", seq, 32'h1b);
        check_eq("rr_drained", 32'(cmd_valid), 0);

        // Re-press of the index being accepted in the same cycle.
        ready = 1'b0;
        for (int f = 1; f <= 20; f++) begin btn[0] = (f <= 10); step(); end
        nacc = 0; bad = 0;
        for (int f = 1; f <= 16; f++) begin
            btn[0] = (f <= 10);
            ready  = (f >= 7);
            if (cmd_valid && ready) begin nacc++; if (cmd_sel != 2'd0) bad++; end
            step();
        end
        check_eq("repress_count", nacc, 2);
        check_eq("repress_sel", bad, 0);

        // Long hold of the test button toggles mode, commands carry the flag.
        do_reset(1);
        ready = 1'b1; ticks = 0; rise = 0;
        for (int k = 1; k <= 250; k++) begin
            btn[4] = 1'b1;
            step();
            ticks += 32'(tick_1s);
            if (test_mode && rise == 0) rise = k;
        end
        check_eq("tick_count", ticks, 2);
        check_eq("mode_rise_step", rise, 200);
        check_eq("mode_on", 32'(test_mode), 1);
        tflag = -1;
        for (int k = 1; k <= 20; k++) begin
            btn[4] = 1'b0; btn[2] = (k <= 10);
            step();
            if (cmd_valid) tflag = 32'(cmd_test);
        end
        check_eq("cmd_test_flag", tflag, 1);
        chg = 0; prev_mode = test_mode;
        for (int k = 1; k <= 250; k++) begin
            btn[4] = 1'b1;
            step();
            if (test_mode != prev_mode) chg++;
            prev_mode = test_mode;
        end
        check_eq("mode_off", 32'(test_mode), 0);
        check_eq("mode_toggles", chg, 1);
        btn[4] = 1'b0;
        repeat (20) step();

        // Reset overrides a stalled command.
        ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin btn[3] = (k <= 10); step(); end
        check_eq("stalled_valid", 32'(cmd_valid), 1);
        check_eq("stalled_sel", 32'(cmd_sel), 3);
        rst_n = 1'b0;
        step();
        check_eq("midrst_valid", 32'(cmd_valid), 0);
        check_eq("midrst_sel", 32'(cmd_sel), 0);
        check_eq("midrst_test", 32'(cmd_test), 0);
        check_eq("midrst_tick", 32'(tick_1s), 0);
        rst_n = 1'b1; ready = 1'b1; vcnt = 0;
        for (int k = 1; k <= 20; k++) begin step(); vcnt += 32'(cmd_valid); end
        check_eq("no_reissue", vcnt, 0);

        // Random traffic against the model.
        for (int i = 0; i < 5; i++) rem[i] = 0;
        rem_l = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (rem[i] == 0) begin
                    btn[i] = 1'($urandom_range(0, 1));
                    rem[i] = (i == 4) ? int'($urandom_range(1, 320)) : int'($urandom_range(1, 14));
                end else rem[i]--;
            end
            if (rem_l == 0) begin
                ledsign = 1'($urandom_range(0, 1));
                rem_l   = int'($urandom_range(1, 40));
            end else rem_l--;
            ready = ($urandom_range(0, 9) < 6);
            rst_n = ($urandom_range(0, 699) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
